// File: rtl/ds_operand_stage.sv
// Decode-stage operand collector: one instruction slot, two sources resolved through
// a priority bypass network plus writeback, captured so they hold under back-pressure.
module ds_operand_stage #(
    parameter int NUM_FWD   = 2,
    parameter int DATA_W    = 32,
    parameter int AW        = 5,
    parameter int PAYLOAD_W = 64,
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_allowin,
    input  logic [PAYLOAD_W-1:0]      in_payload,
    input  logic [AW-1:0]             in_raddr1,
    input  logic [AW-1:0]             in_raddr2,
    output logic [AW-1:0]             rf_raddr1,
    output logic [AW-1:0]             rf_raddr2,
    input  logic [DATA_W-1:0]         rf_rdata1,
    input  logic [DATA_W-1:0]         rf_rdata2,
    input  logic                      wb_we,
    input  logic [AW-1:0]             wb_addr,
    input  logic [DATA_W-1:0]         wb_data,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_ready,
    input  logic [NUM_FWD*AW-1:0]     fwd_dest,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic                      out_valid,
    input  logic                      out_allowin,
    output logic [PAYLOAD_W-1:0]      out_payload,
    output logic [DATA_W-1:0]         out_src1,
    output logic [DATA_W-1:0]         out_src2,
    output logic [CNT_W-1:0]          stall_cnt
);

    logic                 r_slot_valid;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [AW-1:0]        r_raddr1;
    logic [AW-1:0]        r_raddr2;
    logic                 r_cap_flag1;
    logic                 r_cap_flag2;
    logic [DATA_W-1:0]    r_cap_val1;
    logic [DATA_W-1:0]    r_cap_val2;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic [DATA_W:0]      w_res1;
    logic [DATA_W:0]      w_res2;
    logic                 w_ok1;
    logic                 w_ok2;
    logic                 w_out_valid;
    logic                 w_out_fire;
    logic                 w_in_allowin;
    logic                 w_load;

    // Returns {resolved, value}. Channels are walked oldest-first so the youngest
    // matching channel overwrites the result; a matching not-ready channel blocks.
    function automatic logic [DATA_W:0] resolve(
        input logic [AW-1:0]             addr,
        input logic                      cap_flag,
        input logic [DATA_W-1:0]         cap_val,
        input logic [DATA_W-1:0]         rf_data,
        input logic [NUM_FWD-1:0]        fv,
        input logic [NUM_FWD-1:0]        fr,
        input logic [NUM_FWD*AW-1:0]     fd,
        input logic [NUM_FWD*DATA_W-1:0] fdat,
        input logic                      we,
        input logic [AW-1:0]             waddr,
        input logic [DATA_W-1:0]         wdata
    );
        logic [DATA_W:0] r;
        r = {1'b1, rf_data};
        if (we && waddr == addr) begin
            r = {1'b1, wdata};
        end
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fv[i] && fd[i*AW +: AW] == addr) begin
                r = fr[i] ? {1'b1, fdat[i*DATA_W +: DATA_W]} : '0;
            end
        end
        if (cap_flag) begin
            r = {1'b1, cap_val};
        end
        if (addr == '0) begin
            r = {1'b1, {DATA_W{1'b0}}};
        end
        return r;
    endfunction

    assign w_res1 = resolve(r_raddr1, r_cap_flag1, r_cap_val1, rf_rdata1, fwd_valid, fwd_ready,
                            fwd_dest, fwd_data, wb_we, wb_addr, wb_data);
    assign w_res2 = resolve(r_raddr2, r_cap_flag2, r_cap_val2, rf_rdata2, fwd_valid, fwd_ready,
                            fwd_dest, fwd_data, wb_we, wb_addr, wb_data);

    assign w_ok1        = w_res1[DATA_W];
    assign w_ok2        = w_res2[DATA_W];
    assign w_out_valid  = r_slot_valid & w_ok1 & w_ok2 & ~flush;
    assign w_out_fire   = w_out_valid & out_allowin;
    assign w_in_allowin = ~r_slot_valid | w_out_fire;
    assign w_load       = in_valid & w_in_allowin & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_valid <= 1'b0;
            r_payload    <= '0;
            r_raddr1     <= '0;
            r_raddr2     <= '0;
            r_cap_flag1  <= 1'b0;
            r_cap_flag2  <= 1'b0;
            r_cap_val1   <= '0;
            r_cap_val2   <= '0;
            r_stall_cnt  <= '0;
        end else if (flush) begin
            r_slot_valid <= 1'b0;
            r_cap_flag1  <= 1'b0;
            r_cap_flag2  <= 1'b0;
        end else begin
            if (w_load) begin
                r_slot_valid <= 1'b1;
                r_payload    <= in_payload;
                r_raddr1     <= in_raddr1;
                r_raddr2     <= in_raddr2;
                r_cap_flag1  <= 1'b0;
                r_cap_flag2  <= 1'b0;
            end else if (w_out_fire) begin
                r_slot_valid <= 1'b0;
            end else if (r_slot_valid) begin
                // Freeze operands as soon as they resolve so later bypass changes cannot disturb them.
                if (w_ok1 && !r_cap_flag1) begin
                    r_cap_flag1 <= 1'b1;
                    r_cap_val1  <= w_res1[DATA_W-1:0];
                end
                if (w_ok2 && !r_cap_flag2) begin
                    r_cap_flag2 <= 1'b1;
                    r_cap_val2  <= w_res2[DATA_W-1:0];
                end
            end
            if (r_slot_valid && !(w_ok1 && w_ok2) && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign in_allowin  = w_in_allowin;
    assign out_valid   = w_out_valid;
    assign out_payload = r_payload;
    assign out_src1    = w_res1[DATA_W-1:0];
    assign out_src2    = w_res2[DATA_W-1:0];
    assign rf_raddr1   = r_raddr1;
    assign rf_raddr2   = r_raddr2;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: doc/ds_operand_stage.md
Name: ds_operand_stage

Overview:
- Parametrised decode-stage operand collector and pipeline slot. It sits between fetch/decode and execute.
- Holds one instruction payload and reads two source registers from the regfile.
- Resolves each source through a priority bypass network of NUM_FWD forwarding channels plus the writeback port.
- Stalls on not-yet-ready producers, and captures resolved operands so they stay stable across downstream back-pressure.

Parameters:
NUM_FWD, 2, number of forwarding channels; index 0 = youngest = highest priority
DATA_W, 32, register data width
AW, 5, register address width
PAYLOAD_W, 64, opaque decoded-instruction payload width
CNT_W, 16, hazard-stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  kill the slot (branch/exception); sampled at clk edge
in_valid  in  1  upstream instruction valid
in_allowin  out  1  slot can accept an instruction this cycle
in_payload  in  PAYLOAD_W  decoded instruction fields
in_raddr1  in  AW  source 1 register address
in_raddr2  in  AW  source 2 register address
rf_raddr1  out  AW  regfile read address 1 (registered slot address)
rf_raddr2  out  AW  regfile read address 2
rf_rdata1  in  DATA_W  regfile read data 1 (combinational read)
rf_rdata2  in  DATA_W  regfile read data 2
wb_we  in  1  writeback write enable
wb_addr  in  AW  writeback address
wb_data  in  DATA_W  writeback data
fwd_valid  in  NUM_FWD  channel i holds a register-writing instruction
fwd_ready  in  NUM_FWD  channel i result is available this cycle
fwd_dest  in  NUM_FWD*AW  channel i destination, packed, channel i at [i*AW +: AW]
fwd_data  in  NUM_FWD*DATA_W  channel i result, packed
out_valid  out  1  slot valid and both operands resolved
out_allowin  in  1  downstream accepts
out_payload  out  PAYLOAD_W  slot payload
out_src1  out  DATA_W  resolved source 1 value
out_src2  out  DATA_W  resolved source 2 value
stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- State: slot_valid, payload/raddr registers, per operand cap_flag and cap_val, stall_cnt.
- Reset: slot_valid=0, cap flags=0, stall_cnt=0. Hence out_valid=0 and in_allowin=1.
- Handshakes:
  - out_fire = out_valid & out_allowin.
  - in_allowin = !slot_valid | out_fire (combinational).
  - out_valid = slot_valid & res1 & res2 & !flush.
- Load: on in_valid & in_allowin & !flush, register payload/addresses, set slot_valid, clear both cap flags.
- Clear: on out_fire without a new load, slot_valid <= 0.
- Flush has top priority: slot_valid <= 0, cap flags cleared, any concurrent load discarded.
- Per-operand resolution (combinational, per cycle, for address a):
  - a==0: value 0, resolved.
  - cap_flag set: value cap_val, resolved.
  - Otherwise scan channels i=0..NUM_FWD-1; the first with fwd_valid[i] & fwd_dest[i]==a decides:
    - fwd_ready[i]=1: value fwd_data[i], resolved.
    - fwd_ready[i]=0: unresolved (hazard). There is no fall-through to older channels.
  - No channel matches: wb_we & wb_addr==a gives wb_data, else rf_rdata. Both are resolved.
- Capture: each cycle with slot_valid & !out_fire & !flush, any resolved operand with cap_flag=0 writes cap_val <= its value and sets cap_flag. Captured values never change until the next load.
- stall_cnt: +1 each cycle with slot_valid & !(res1 & res2) & !flush. Saturates at all-ones; it does not wrap.
- A downstream stall (out_allowin=0 while out_valid=1) is not counted.
- Latency: an instruction with no hazards is presented on out_* the cycle after it is loaded.
- Simultaneous events: out_fire and load in the same cycle replace the slot with no bubble. Address equal on both operands is resolved independently and identically.

Test Plan:
- No hazard, back-to-back: load r3/r4 with rf_rdata=0x11/0x22 and out_allowin=1 held -> out_valid the next cycle, src=0x11/0x22, in_allowin stays 1, one instruction out per cycle.
- Priority: ch0 and ch1 both match r5, ch0 ready data 0xAAAA, ch1 data 0xBBBB -> src1=0xAAAA. With ch0 not ready -> out_valid=0 even though ch1 is ready, and stall_cnt increments.
- Load-use: ch0 valid/not-ready on r7 for 3 cycles, then ready with 0x1234 -> out_valid rises in cycle 4, src1=0x1234, stall_cnt=3.
- Capture under back-pressure: src2 resolved from ch1=0x55 while out_allowin=0, then ch1 leaves (fwd_valid=0) and rf_rdata2=0x99 -> src2 stays 0x55 until fire.
- r0 and writeback: raddr1=0 with ch0 dest=0 not-ready -> src1=0, no stall. wb_we to r9 with 0x77 while rf_rdata=0x0 -> src=0x77.
- Flush and saturation: flush asserted with in_valid=1 -> slot empty next cycle, out_valid=0. With CNT_W=2 and 5 hazard cycles -> stall_cnt=3. Reset mid-stall -> all outputs return to reset values.
